// File: rtl/ls280_parity_pkg.sv
// Shared types for the 9-bit parity block.
// Holds the word width and the bit-ordering type used to pack the a..i inputs.
package ls280_parity_pkg;

  localparam int PAR_W = 9;

  typedef logic [PAR_W-1:0] par_word_t;

endpackage

// File: rtl/ls280_parity_comb.sv
// 9-input XOR tree producing odd/even parity; purely combinational, zero latency.
// Independent of clock and reset, so the outputs stay valid while the block is held in reset.
module parity9_comb
  import ls280_parity_pkg::*;
(
  input  par_word_t i_data,
  output logic      o_odd,
  output logic      o_even
);

  logic [3:0] w_l1;
  logic [1:0] w_l2;
  logic       w_l3;

  // Balanced pairing of bits 0..7; bit 8 (the parity bit when checking) joins last.
  assign w_l1[0] = i_data[0] ^ i_data[1];
  assign w_l1[1] = i_data[2] ^ i_data[3];
  assign w_l1[2] = i_data[4] ^ i_data[5];
  assign w_l1[3] = i_data[6] ^ i_data[7];
  assign w_l2[0] = w_l1[0] ^ w_l1[1];
  assign w_l2[1] = w_l1[2] ^ w_l1[3];
  assign w_l3    = w_l2[0] ^ w_l2[1];

  assign o_odd  = w_l3 ^ i_data[8];
  assign o_even = ~o_odd;

endmodule

// File: rtl/ls280_parity.sv
// 74LS280-equivalent parity generator/checker: combinational odd/even plus a 1-cycle registered copy,
// a per-cycle mismatch flag and a saturating mismatch counter.
module ls280_parity
  import ls280_parity_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  input  logic             e,
  input  logic             f,
  input  logic             g,
  input  logic             h,
  input  logic             i,
  output logic             odd,
  output logic             even,
  input  logic             check_en,
  input  logic             exp_odd,
  output logic             odd_q,
  output logic             even_q,
  output logic             par_err,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  par_word_t        w_data;
  logic             w_odd;
  logic             w_even;
  logic             w_mismatch;

  logic             r_odd_q;
  logic             r_even_q;
  logic             r_par_err;
  logic [CNT_W-1:0] r_err_count;

  assign w_data = {i, h, g, f, e, d, c, b, a};

  parity9_comb u_comb (
    .i_data (w_data),
    .o_odd  (w_odd),
    .o_even (w_even)
  );

  assign odd  = w_odd;
  assign even = w_even;

  assign w_mismatch = check_en & (w_odd != exp_odd);

  // Reset values match what the all-zero input word would register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_odd_q     <= 1'b0;
      r_even_q    <= 1'b1;
      r_par_err   <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_odd_q   <= w_odd;
      r_even_q  <= w_even;
      r_par_err <= w_mismatch;
      if (w_mismatch && (r_err_count != CNT_MAX)) begin
        r_err_count <= r_err_count + CNT_ONE;
      end
    end
  end

  assign odd_q     = r_odd_q;
  assign even_q    = r_even_q;
  assign par_err   = r_par_err;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_ls280_parity.sv
// Scoreboard bench for ls280_parity: driver pushes expected registered results, monitor pops each edge.
// Combinational outputs are checked directly against a popcount-based reference.
module tb_ls280_parity;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset_n;
  logic             a, b, c, d, e, f, g, h, i;
  logic             odd, even;
  logic             check_en, exp_odd;
  logic             odd_q, even_q, par_err;
  logic [CNT_W-1:0] err_count;

  typedef struct packed {
    logic             odd_q;
    logic             even_q;
    logic             par_err;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_cnt  = 0;

  ls280_parity #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .e         (e),
    .f         (f),
    .g         (g),
    .h         (h),
    .i         (i),
    .odd       (odd),
    .even      (even),
    .check_en  (check_en),
    .exp_odd   (exp_odd),
    .odd_q     (odd_q),
    .even_q    (even_q),
    .par_err   (par_err),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Drive one cycle of stimulus, check combinational outputs, queue the expected registered state.
  task automatic step(input logic [8:0] data, input logic chk, input logic xo, input logic rst_n);
    exp_t ex;
    logic m_odd;
    logic mism;
    reset_n  = rst_n;
    check_en = chk;
    exp_odd  = xo;
    {i, h, g, f, e, d, c, b, a} = data;
    #1;
    m_odd = ($countones(data) % 2) == 1;
    check("comb_odd", {7'd0, odd}, {7'd0, m_odd});
    check("comb_even", {7'd0, even}, {7'd0, ~m_odd});
    if (!rst_n) begin
      m_cnt      = 0;
      ex.odd_q   = 1'b0;
      ex.even_q  = 1'b1;
      ex.par_err = 1'b0;
    end else begin
      mism = chk && (m_odd != xo);
      if (mism && m_cnt < CNT_MAX) m_cnt++;
      ex.odd_q   = m_odd;
      ex.even_q  = ~m_odd;
      ex.par_err = mism;
    end
    ex.cnt = m_cnt[CNT_W-1:0];
    q.push_back(ex);
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    exp_t ex;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        ex = q.pop_front();
        check("sb_odd_q", {7'd0, odd_q}, {7'd0, ex.odd_q});
        check("sb_even_q", {7'd0, even_q}, {7'd0, ex.even_q});
        check("sb_par_err", {7'd0, par_err}, {7'd0, ex.par_err});
        check("sb_err_count", {{(8-CNT_W){1'b0}}, err_count}, {{(8-CNT_W){1'b0}}, ex.cnt});
      end
    end
  end

  logic [8:0] spot_v [4];
  logic       spot_o [4];
  logic [1:0] sat_seq [5];

  initial begin : driver
    logic [8:0] rd;
    spot_v  = '{9'h000, 9'h001, 9'h1FF, 9'h003};
    spot_o  = '{1'b0, 1'b1, 1'b1, 1'b0};
    sat_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    step(9'h000, 1'b0, 1'b0, 1'b0);
    step(9'h000, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 4; k++) begin
      step(spot_v[k], 1'b0, 1'b0, 1'b1);
      check("spot_odd", {7'd0, odd}, {7'd0, spot_o[k]});
      check("spot_even", {7'd0, even}, {7'd0, ~spot_o[k]});
    end

    for (int idx = 0; idx < 512; idx++) begin
      rd = idx[8:0];
      step(rd, 1'b0, 1'b0, 1'b1);
    end

    // Combinational path live while registers held in reset.
    step(9'h007, 1'b0, 1'b0, 1'b0);
    check("rst_odd", {7'd0, odd}, 8'd1);
    check("rst_even", {7'd0, even}, 8'd0);
    check("rst_odd_q", {7'd0, odd_q}, 8'd0);
    check("rst_even_q", {7'd0, even_q}, 8'd1);
    check("rst_err_count", {6'd0, err_count}, 8'd0);

    {i, h, g, f, e, d, c, b, a} = 9'h015;
    reset_n = 1'b1;
    #1;
    check("lat_before_odd_q", {7'd0, odd_q}, 8'd0);
    step(9'h015, 1'b0, 1'b0, 1'b1);
    check("lat_after_odd_q", {7'd0, odd_q}, 8'd1);
    check("lat_after_even_q", {7'd0, even_q}, 8'd0);

    step(9'h080, 1'b1, 1'b1, 1'b1);
    check("chk_ok_par_err", {7'd0, par_err}, 8'd0);
    check("chk_ok_cnt", {6'd0, err_count}, 8'd0);
    step(9'h180, 1'b1, 1'b1, 1'b1);
    check("chk_bad_par_err", {7'd0, par_err}, 8'd1);
    check("chk_bad_cnt", {6'd0, err_count}, 8'd1);
    step(9'h180, 1'b0, 1'b1, 1'b1);
    check("chk_off_par_err", {7'd0, par_err}, 8'd0);
    check("chk_off_cnt", {6'd0, err_count}, 8'd1);

    step(9'h000, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(9'h180, 1'b1, 1'b1, 1'b1);
      check("sat_cnt", {6'd0, err_count}, {6'd0, sat_seq[k]});
    end

    step(9'h180, 1'b1, 1'b1, 1'b0);
    check("midrst_cnt", {6'd0, err_count}, 8'd0);
    check("midrst_par_err", {7'd0, par_err}, 8'd0);
    check("midrst_odd_q", {7'd0, odd_q}, 8'd0);
    check("midrst_even_q", {7'd0, even_q}, 8'd1);

    for (int k = 0; k < 400; k++) begin
      rd = 9'($urandom_range(0, 511));
      step(rd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 19) != 0));
    end

    @(posedge clk);
    #2;
    check("sb_drain", 8'(q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ls280_parity.md
Name: ls280_parity

Overview:
- 9-bit odd/even parity generator/checker, functionally equivalent to the 74LS280.
- Used in the RAM subsystem to generate and check memory parity over 8 data bits plus the parity bit.
- The primary parity outputs are purely combinational.
- A clocked side section registers the parity result and provides an optional parity-error checker with a saturating error counter.

Parameters:
- CNT_W, 8, width of the parity-error counter (saturates at 2^CNT_W-1).

Ports:
- clk  input  1  system clock; all registers update on the rising edge
- reset_n  input  1  synchronous, active-low reset
- a  input  1  data bit 0
- b  input  1  data bit 1
- c  input  1  data bit 2
- d  input  1  data bit 3
- e  input  1  data bit 4
- f  input  1  data bit 5
- g  input  1  data bit 6
- h  input  1  data bit 7
- i  input  1  data bit 8 (parity bit when checking)
- odd  output  1  combinational; 1 when an odd number of a..i are 1
- even  output  1  combinational; always the complement of odd
- check_en  input  1  when 1 at a clock edge, the current inputs are checked
- exp_odd  input  1  expected value of odd during a check
- odd_q  output  1  registered odd
- even_q  output  1  registered even
- par_err  output  1  registered mismatch flag
- err_count  output  CNT_W  saturating count of detected mismatches

Behaviour:
- Interface: one clock, clk; reset_n is synchronous and active-low.
- Combinational outputs:
  - odd = a^b^c^d^e^f^g^h^i.
  - even = ~odd.
  - Zero latency: outputs settle within the same delta/time step as an input change, with no clock required.
  - Outputs are independent of clk and reset_n; they stay valid while reset_n=0.
  - odd and even are never equal. No X is generated for known inputs.
- Registered stage, every rising clk edge:
  - If reset_n=0: odd_q<=0, even_q<=1, par_err<=0, err_count<=0.
  - Else: odd_q<=odd and even_q<=even (1-cycle latency).
    - par_err <= check_en & (odd != exp_odd). The flag is not sticky; it reflects only the previous cycle's check.
    - err_count increments by 1 when check_en & (odd != exp_odd). It holds at all-ones and never wraps.
- Reset values: odd_q=0, even_q=1, par_err=0, err_count=0. These are consistent with the all-zero input state.
- Simultaneous events: reset has priority over check and increment.
- check_en=0: par_err<=0 and err_count holds.

Decomposition:
- No shared package is needed.
- Optional single sub-module parity9_comb (9-input XOR tree producing odd/even), instanced once.
- The register and checker logic lives in the top level.

Test Plan:
- Exhaustive combinational check: sweep {i,h,g,f,e,d,c,b,a} over 0..511, sampling 1 time unit after each change. Required: odd equals the XOR of the 9 bits, even equals ~odd, and 0 mismatches. Spot values: 0 -> odd=0 even=1; 9'h001 -> odd=1 even=0; 9'h1FF -> odd=1 even=0; 9'h003 -> odd=0 even=1.
- Combinational outputs under reset: hold reset_n=0 and apply 9'h007. Required: odd=1 and even=0 immediately, while odd_q=0, even_q=1 and err_count=0 after the edge.
- Registered latency: release reset and apply 9'h015 before edge N. Required: odd_q=1 and even_q=0 only after edge N.
- Checker: apply 9'h080 with exp_odd=1 and check_en=1 -> par_err=0 next cycle and err_count unchanged. Apply 9'h180 with exp_odd=1 -> par_err=1 and err_count=1. Then drop check_en -> par_err=0 and err_count stays 1.
- Saturation: with CNT_W=2, force 5 consecutive mismatching checks. Required: err_count sequence 1, 2, 3, 3, 3.
- Reset mid-operation: with err_count=3 and a mismatching check active, assert reset_n=0 for one edge. Required: err_count=0, par_err=0, odd_q=0 and even_q=1.
